// File: rtl/axi_light_pkg.sv
// Shared AXI-lite types for the register slave: response codes, FSM states,
// the byte-strobe merge function, and the default bus-width macros.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_WSTRB_WIDTH
`define AXI_WSTRB_WIDTH 4
`endif

package axi_light_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    return res;
  endfunction
endpackage

// File: rtl/if_axi_light.sv
// AXI-lite bundle with master and slave views.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_WSTRB_WIDTH
`define AXI_WSTRB_WIDTH 4
`endif

interface if_axi_light;
  logic [`AXI_ADDR_WIDTH-1:0]  awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [`AXI_DATA_WIDTH-1:0]  wdata;
  logic [`AXI_WSTRB_WIDTH-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [`AXI_ADDR_WIDTH-1:0]  araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [`AXI_DATA_WIDTH-1:0]  rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_light_addr_decode.sv
// Maps a byte address onto the register window: hit flag plus word index.
module axi_light_addr_decode #(
  parameter logic [31:0]  BASE_ADDR = 32'h0000_0000,
  parameter int unsigned  NUM_REGS  = 8,
  localparam int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] index
);
  logic [31:0] off;

  always_comb begin
    off   = addr - BASE_ADDR;
    hit   = (addr >= BASE_ADDR) && (off < 32'(NUM_REGS * 4));
    index = off[IDX_W+1:2];
  end
endmodule

// File: rtl/axi_light_reg_slave.sv
// AXI-lite register bank target: independent write and read FSMs, one
// outstanding transaction each, registers exported flat with write pulses.
module axi_light_reg_slave
  import axi_light_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_REGS  = 8,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     res,
  if_axi_light.slave               s_axi,
  output logic [NUM_REGS*32-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);
  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [31:0] regs [NUM_REGS];

  w_state_t    w_state, w_state_n;
  logic        aw_lat, w_lat, aw_lat_n, w_lat_n;
  logic        awready_q, wready_q, aw_hs, w_hs, commit, do_write;
  logic [31:0] aw_addr_q, w_data_q, wr_addr, wr_data;
  logic [3:0]  w_strb_q, wr_strb;
  logic        wr_hit;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]  bresp_q;

  r_state_t    r_state, r_state_n;
  logic        arready_q, ar_hs, rd_hit;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = (w_state == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = (r_state == R_RESP);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  // Commit uses the incoming beat directly when it completes the pair this cycle.
  always_comb begin
    aw_hs   = s_axi.awvalid & awready_q;
    w_hs    = s_axi.wvalid & wready_q;
    wr_addr = aw_lat ? aw_addr_q : s_axi.awaddr;
    wr_data = w_lat ? w_data_q : s_axi.wdata;
    wr_strb = w_lat ? w_strb_q : s_axi.wstrb;
  end

  axi_light_addr_decode #(.BASE_ADDR(BASE_ADDR), .NUM_REGS(NUM_REGS)) u_wr_dec (
    .addr(wr_addr), .hit(wr_hit), .index(wr_idx)
  );

  axi_light_addr_decode #(.BASE_ADDR(BASE_ADDR), .NUM_REGS(NUM_REGS)) u_rd_dec (
    .addr(s_axi.araddr), .hit(rd_hit), .index(rd_idx)
  );

  always_comb begin
    w_state_n = w_state;
    aw_lat_n  = aw_lat | aw_hs;
    w_lat_n   = w_lat | w_hs;
    commit    = 1'b0;
    unique case (w_state)
      W_IDLE: if (aw_lat_n && w_lat_n) begin
        commit    = 1'b1;
        w_state_n = W_RESP;
      end
      W_RESP: if (s_axi.bready) begin
        w_state_n = W_IDLE;
        aw_lat_n  = 1'b0;
        w_lat_n   = 1'b0;
      end
    endcase
    do_write = commit && wr_hit && (|wr_strb);
  end

  always_comb begin
    r_state_n = r_state;
    ar_hs     = s_axi.arvalid & arready_q;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_state_n = R_RESP;
      R_RESP: if (s_axi.rready) r_state_n = R_IDLE;
    endcase
  end

  // Readies are registered from next state so no input reaches them combinationally.
  always_ff @(posedge clk) begin
    if (res) begin
      w_state    <= W_IDLE;
      aw_lat     <= 1'b0;
      w_lat      <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_o <= '0;
      r_state    <= R_IDLE;
      arready_q  <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      w_state   <= w_state_n;
      aw_lat    <= aw_lat_n;
      w_lat     <= w_lat_n;
      awready_q <= (w_state_n == W_IDLE) && !aw_lat_n;
      wready_q  <= (w_state_n == W_IDLE) && !w_lat_n;
      if (commit) bresp_q <= wr_hit ? RESP_OKAY : RESP_DECERR;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        wr_pulse_o[i] <= do_write && (wr_idx == IDX_W'(i));
        if (do_write && (wr_idx == IDX_W'(i)))
          regs[i] <= strb_merge(regs[i], wr_data, wr_strb);
      end
      r_state   <= r_state_n;
      arready_q <= (r_state_n == R_IDLE);
      if (ar_hs) begin
        rdata_q <= rd_hit ? regs[rd_idx] : '0;
        rresp_q <= rd_hit ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr_q <= s_axi.awaddr;
    if (w_hs) begin
      w_data_q <= s_axi.wdata;
      w_strb_q <= s_axi.wstrb;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_o[32*i +: 32] = regs[i];
  end
endmodule

// File: tb/tb_axi_light_reg_slave.sv
// Directed bench for axi_light_reg_slave: inputs driven and outputs sampled on negedge.
module tb_axi_light_reg_slave;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned NREGS = 8;
  localparam logic [31:0] RVAL  = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic res;
  logic [NREGS*32-1:0] regs_o;
  logic [NREGS-1:0]    wr_pulse_o;
  int n_cmp = 0;
  int n_err = 0;

  if_axi_light axi ();

  axi_light_reg_slave #(.BASE_ADDR(BASE), .NUM_REGS(NREGS), .RESET_VAL(RVAL)) dut (
    .clk(clk), .res(res), .s_axi(axi), .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_at(input int i);
    return regs_o[32*i +: 32];
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic [7:0] pulse);
    int n;
    logic aw_done, w_done;
    @(negedge clk);
    axi.awaddr = addr; axi.awvalid = 1'b1;
    axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1;
    axi.bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      if (axi.awvalid && axi.awready) aw_done = 1'b1;
      if (axi.wvalid && axi.wready) w_done = 1'b1;
      @(negedge clk);
      n++;
      if (aw_done) axi.awvalid = 1'b0;
      if (w_done) axi.wvalid = 1'b0;
    end
    n = 0;
    while (!axi.bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wr_bvalid_seen", {31'b0, axi.bvalid}, 32'd1);
    resp  = axi.bresp;
    pulse = wr_pulse_o;
    @(negedge clk);
    axi.bready = 1'b0;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    @(negedge clk);
    axi.araddr = addr; axi.arvalid = 1'b1; axi.rready = 1'b1;
    n = 0;
    while (!axi.arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    axi.arvalid = 1'b0;
    n = 0;
    while (!axi.rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rd_rvalid_seen", {31'b0, axi.rvalid}, 32'd1);
    data = axi.rdata;
    resp = axi.rresp;
    @(negedge clk);
    axi.rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [7:0]  pulse;
    logic [31:0] data;

    res = 1'b1;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bvalid", {31'b0, axi.bvalid}, 32'd0);
    check("rst_rvalid", {31'b0, axi.rvalid}, 32'd0);
    check("rst_readies", {29'b0, axi.awready, axi.wready, axi.arready}, 32'd0);
    check("rst_pulse", {24'b0, wr_pulse_o}, 32'd0);
    check("rst_rdata", axi.rdata, 32'd0);
    check("rst_reg0", reg_at(0), RVAL);
    check("rst_reg7", reg_at(7), RVAL);
    res = 1'b0;
    @(negedge clk);
    check("idle_readies", {29'b0, axi.awready, axi.wready, axi.arready}, 32'd7);

    // AW and W in the same cycle
    axi.awaddr = BASE + 32'd8; axi.awvalid = 1'b1;
    axi.wdata = 32'hDEAD_BEEF; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    check("t1_bvalid", {31'b0, axi.bvalid}, 32'd1);
    check("t1_bresp", {30'b0, axi.bresp}, 32'd0);
    check("t1_reg2", reg_at(2), 32'hDEAD_BEEF);
    check("t1_pulse", {24'b0, wr_pulse_o}, 32'h04);
    check("t1_wait_readies", {30'b0, axi.awready, axi.wready}, 32'd0);
    @(negedge clk);
    check("t1_pulse_once", {24'b0, wr_pulse_o}, 32'h00);
    check("t1_bvalid_hold", {31'b0, axi.bvalid}, 32'd1);
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    check("t1_bvalid_clear", {31'b0, axi.bvalid}, 32'd0);

    // W three cycles ahead of AW
    @(negedge clk);
    axi.wdata = 32'h1234_5678; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    @(negedge clk);
    axi.wvalid = 1'b0;
    check("t2_wready_drop", {31'b0, axi.wready}, 32'd0);
    check("t2_awready_kept", {31'b0, axi.awready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("t2_no_early_commit", reg_at(1), RVAL);
    check("t2_no_early_b", {31'b0, axi.bvalid}, 32'd0);
    axi.awaddr = BASE + 32'd4; axi.awvalid = 1'b1;
    @(negedge clk);
    axi.awvalid = 1'b0;
    check("t2_bvalid", {31'b0, axi.bvalid}, 32'd1);
    check("t2_reg1", reg_at(1), 32'h1234_5678);
    check("t2_pulse", {24'b0, wr_pulse_o}, 32'h02);
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    axi_read(BASE + 32'd4, data, resp);
    check("t2_rdata", data, 32'h1234_5678);
    check("t2_rresp", {30'b0, resp}, 32'd0);

    // Partial strobe; unaligned address bits ignored
    axi_write(BASE + 32'd5, 32'hAABB_CCDD, 4'b0101, resp, pulse);
    check("t3_bresp", {30'b0, resp}, 32'd0);
    check("t3_reg1", reg_at(1), 32'h12BB_56DD);
    axi_read(BASE + 32'd6, data, resp);
    check("t3_rdata", data, 32'h12BB_56DD);

    // Zero strobe on a hit: OKAY, no update, no pulse
    axi_write(BASE + 32'd4, 32'hFFFF_FFFF, 4'b0000, resp, pulse);
    check("zs_bresp", {30'b0, resp}, 32'd0);
    check("zs_pulse", {24'b0, pulse}, 32'd0);
    check("zs_reg1", reg_at(1), 32'h12BB_56DD);

    // Last register in window is a hit
    axi_write(BASE + 32'h1C, 32'h7777_0007, 4'hF, resp, pulse);
    check("edge_bresp", {30'b0, resp}, 32'd0);
    check("edge_pulse", {24'b0, pulse}, 32'h80);
    check("edge_reg7", reg_at(7), 32'h7777_0007);

    // Out of range above and below
    axi_write(BASE + 32'h20, 32'h0BAD_0BAD, 4'hF, resp, pulse);
    check("oor_hi_bresp", {30'b0, resp}, 32'd3);
    check("oor_hi_pulse", {24'b0, pulse}, 32'd0);
    axi_write(BASE - 32'd4, 32'h0BAD_0BAD, 4'hF, resp, pulse);
    check("oor_lo_bresp", {30'b0, resp}, 32'd3);
    check("oor_lo_pulse", {24'b0, pulse}, 32'd0);
    check("oor_reg0", reg_at(0), RVAL);
    check("oor_reg1", reg_at(1), 32'h12BB_56DD);
    check("oor_reg2", reg_at(2), 32'hDEAD_BEEF);
    check("oor_reg7", reg_at(7), 32'h7777_0007);
    axi_read(BASE + 32'h20, data, resp);
    check("oor_hi_rresp", {30'b0, resp}, 32'd3);
    check("oor_hi_rdata", data, 32'd0);
    axi_read(BASE - 32'd4, data, resp);
    check("oor_lo_rresp", {30'b0, resp}, 32'd3);
    check("oor_lo_rdata", data, 32'd0);

    // Read backpressure
    @(negedge clk);
    axi.araddr = BASE + 32'd8; axi.arvalid = 1'b1; axi.rready = 1'b0;
    @(negedge clk);
    axi.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rbp_rvalid", {31'b0, axi.rvalid}, 32'd1);
      check("rbp_rdata", axi.rdata, 32'hDEAD_BEEF);
      check("rbp_arready", {31'b0, axi.arready}, 32'd0);
      @(negedge clk);
    end
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    check("rbp_rvalid_clear", {31'b0, axi.rvalid}, 32'd0);

    // Write backpressure
    axi.awaddr = BASE + 32'd12; axi.awvalid = 1'b1;
    axi.wdata = 32'h3333_3333; axi.wstrb = 4'hF; axi.wvalid = 1'b1; axi.bready = 1'b0;
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("wbp_bvalid", {31'b0, axi.bvalid}, 32'd1);
      check("wbp_bresp", {30'b0, axi.bresp}, 32'd0);
      check("wbp_readies", {30'b0, axi.awready, axi.wready}, 32'd0);
      @(negedge clk);
    end
    check("wbp_reg3", reg_at(3), 32'h3333_3333);
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    check("wbp_bvalid_clear", {31'b0, axi.bvalid}, 32'd0);

    // Read and write in the same cycle: read sees the pre-write value
    @(negedge clk);
    axi.awaddr = BASE; axi.awvalid = 1'b1;
    axi.wdata = 32'h5555_AAAA; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    axi.araddr = BASE; axi.arvalid = 1'b1;
    axi.bready = 1'b1; axi.rready = 1'b1;
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    check("col_rdata_old", axi.rdata, RVAL);
    check("col_reg0_new", reg_at(0), 32'h5555_AAAA);
    @(negedge clk);
    axi.bready = 1'b0; axi.rready = 1'b0;
    axi_read(BASE, data, resp);
    check("col_read_after", data, 32'h5555_AAAA);

    // Reset while a B response is held and an AR is presented
    axi.awaddr = BASE + 32'd20; axi.awvalid = 1'b1;
    axi.wdata = 32'h6666_6666; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    check("mr_bvalid_pre", {31'b0, axi.bvalid}, 32'd1);
    axi.araddr = BASE + 32'd8; axi.arvalid = 1'b1; axi.rready = 1'b0;
    res = 1'b1;
    @(negedge clk);
    check("mr_bvalid", {31'b0, axi.bvalid}, 32'd0);
    check("mr_rvalid", {31'b0, axi.rvalid}, 32'd0);
    check("mr_readies", {29'b0, axi.awready, axi.wready, axi.arready}, 32'd0);
    for (int i = 0; i < 8; i++) check("mr_regs", reg_at(i), RVAL);
    res = 1'b0; axi.arvalid = 1'b0;
    @(negedge clk);
    check("mr_rvalid_after", {31'b0, axi.rvalid}, 32'd0);
    axi_write(BASE + 32'd12, 32'h0BAD_F00D, 4'hF, resp, pulse);
    check("mr_post_bresp", {30'b0, resp}, 32'd0);
    check("mr_post_pulse", {24'b0, pulse}, 32'h08);
    check("mr_post_reg3", reg_at(3), 32'h0BAD_F00D);
    check("mr_post_reg2", reg_at(2), RVAL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
